// File: rtl/lut_neuron_cfg.sv
// lut_neuron_cfg: runtime-loadable truth-table neuron (stream-filled LUT + lookup).
// Ports: clk, rst_n | cfg_start/valid/ready/data, cfg_done, lut_loaded |
//        in_valid/in_data -> out_valid/out_data (1-cycle latency), lookup_drop.
module lut_neuron_cfg #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2,
   parameter int CFG_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CFG_W-1:0]    cfg_data,
   output logic                cfg_done,
   output logic                lut_loaded,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] out_data,
   output logic                lookup_drop
);

   localparam int EPB    = CFG_W / OUT_BITS;
   localparam int DEPTH  = 2 ** IN_BITS;
   localparam int NBEATS = DEPTH / EPB;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [BW-1:0]       beat_cnt;
   logic [BW-1:0]       beat_nx;
   logic                accept;
   logic                last_beat;
   logic                run;
   logic [OUT_BITS-1:0] mem [DEPTH];

   assign run        = (state == RUN);
   assign lut_loaded = run;
   assign last_beat  = accept && (beat_cnt == LAST);

   always_comb begin
      state_nx  = state;
      beat_nx   = beat_cnt;
      cfg_ready = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cfg_start) begin
               state_nx = LOAD;
               beat_nx  = '0;
            end
         end
         LOAD: begin
            // A start pulse restarts the load and refuses that cycle's beat
            if (cfg_start) begin
               beat_nx = '0;
            end else begin
               cfg_ready = 1'b1;
               accept    = cfg_valid;
               if (accept) begin
                  if (beat_cnt == LAST) begin
                     state_nx = RUN;
                     beat_nx  = '0;
                  end else begin
                     beat_nx = beat_cnt + BW'(1);
                  end
               end
            end
         end
         RUN: begin
            if (cfg_start) begin
               state_nx = LOAD;
               beat_nx  = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            beat_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         cfg_done    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         lookup_drop <= 1'b0;
      end else begin
         state       <= state_nx;
         beat_cnt    <= beat_nx;
         cfg_done    <= last_beat;
         out_valid   <= in_valid && run;
         lookup_drop <= in_valid && !run;
         // Lookup uses the current state, so a RUN->LOAD cycle still answers
         if (in_valid && run) begin
            out_data <= mem[in_data];
         end
      end
   end

   // Table storage: no reset, contents only observable after a full load.
   // Lowest entry index of a beat is packed in its LSBs.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < EPB; k++) begin
            mem[IN_BITS'(int'(beat_cnt) * EPB + k)] <=
               cfg_data[k*OUT_BITS +: OUT_BITS];
         end
      end
   end

endmodule
